vram_write_port: RTL and testbench
==================================

# vram_write_port

CPU-facing write path into the GPU's video memories: tile memory, attribute memory (character attributes plus glyph bitmaps) and color palette memory. It decodes a small register file driven by the CPU bus, keeps a 16-bit auto-incrementing VRAM pointer and issues single-cycle write strobes on the write ports of those memories. The pixel generator reads the same memories on their read ports. A fill engine writes one byte value to N consecutive locations without CPU involvement.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock (same clock as the pixel generator fetch logic)
- rst  in  1  asynchronous, active-low reset
- cpu_reg_sel  in  3  register select
- cpu_data_in  in  8  CPU write data
- cpu_write_strobe  in  1  write request, synchronous to clk; rising edge (high now, low previous cycle) = one register write
- cpu_data_out  out  8  combinational readback of the selected register
- tile_memory_write_addr  out  11  tile memory address
- tile_memory_write_data  out  8  tile memory data
- tile_memory_write_enable  out  1  one-cycle write pulse
- attribute_memory_write_addr  out  12  attribute/glyph memory address
- attribute_memory_write_data  out  8  attribute/glyph memory data
- attribute_memory_write_enable  out  1  one-cycle write pulse
- color_memory_write_addr  out  4  palette index
- color_memory_write_data  out  8  palette entry
- color_memory_write_enable  out  1  one-cycle write pulse

## Operation
- Registers by cpu_reg_sel:
  - 0 ADDR_LO: pointer[7:0].
  - 1 ADDR_HI: pointer[15:8].
  - 2 DATA: write = one VRAM write at pointer, then pointer += INC. Readback returns the last byte written.
  - 3 INC: 8-bit step. 0 = pointer holds.
  - 4 FILL_VALUE.
  - 5 FILL_COUNT: a write of N>0 starts a fill of N bytes. N=0 is a no-op. Readback returns the remaining count.
  - 6 STATUS: read-only. bit0 = busy; other bits 0.
  - 7 reserved: writes ignored, reads 0.
- Address decode on the pointer P:
  - 0x0000–0x07FF → tile, addr P[10:0].
  - 0x1000–0x1FFF → attribute, addr P[11:0].
  - 0x2000–0x200F → color, addr P[3:0].
  - Anything else → no enable asserted; the pointer still advances.
- Pointer arithmetic: 16-bit, P + zero-extended INC, wraps modulo 65536.
- States:
  - IDLE → WRITE on a DATA strobe; WRITE → IDLE after 1 cycle.
  - IDLE → FILL on a FILL_COUNT strobe with N>0. FILL issues one write per cycle, decrementing the count. It returns to IDLE in the cycle after the write that brings the count to 0.
- busy = (state != IDLE).
- While busy, all CPU register writes are dropped. Strobe edge detection keeps running, so a strobe held across busy never fires late.
- At most one write enable is high in any cycle. Write addr/data outputs hold their last values when their enable is low.

## Timing
- Reset: every output 0; pointer 0x0000; INC 1; FILL_VALUE 0; count 0; DATA readback 0; state IDLE; strobe history 0.
- DATA strobe edge sampled at cycle T:
  - enable, addr and data are valid during T+1.
  - The pointer shows the incremented value from T+1 (readable T+1 onward).
- FILL_COUNT = N sampled at T:
  - writes in cycles T+1 … T+N at P, P+INC, P+2·INC, …
  - busy is high T+1 … T+N.
  - Final pointer = P + N·INC (mod 2^16).
- ADDR/INC/FILL_VALUE writes take effect at T+1.
- Readback is combinational from current register state.
- Reset asserted mid-fill aborts immediately: enables drop to 0 asynchronously, all state returns to reset values.

## Test plan
- Reset check: all enables 0, STATUS=0x00, INC readback=1, ADDR_LO/HI=0.
- Write ADDR_HI=0x00, ADDR_LO=0x05, DATA=0xA7 → tile write pulse addr 0x005, data 0xA7, exactly one cycle. Pointer reads 0x0006.
- Pointer 0x1ABC, DATA=0x3C → attribute write addr 0xABC. Pointer 0x2003, DATA=0x1F → color addr 3. Pointer 0x2010, DATA=0x55 → no enable, pointer 0x2011.
- INC=2, pointer 0x1000, FILL_VALUE=0xFF, FILL_COUNT=4 → attribute writes at 0x000, 0x002, 0x004, 0x006 on 4 consecutive cycles. busy high for 4 cycles. Pointer ends 0x1008. A DATA write issued mid-fill is dropped.
- cpu_write_strobe held high 5 cycles on DATA → exactly one write. Pointer 0xFFFF with INC=1 → wraps to 0x0000.
- Reset pulsed during a FILL of 200 → enables low immediately. After release, STATUS=0 and pointer=0.

Source files
------------

// File: rtl/vram_write_port.sv
// vram_write_port: CPU register file feeding tile/attribute/palette write ports with auto-increment pointer and fill engine
module vram_write_port (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  cpu_reg_sel,
   input  logic [7:0]  cpu_data_in,
   input  logic        cpu_write_strobe,
   output logic [7:0]  cpu_data_out,
   output logic [10:0] tile_memory_write_addr,
   output logic [7:0]  tile_memory_write_data,
   output logic        tile_memory_write_enable,
   output logic [11:0] attribute_memory_write_addr,
   output logic [7:0]  attribute_memory_write_data,
   output logic        attribute_memory_write_enable,
   output logic [3:0]  color_memory_write_addr,
   output logic [7:0]  color_memory_write_data,
   output logic        color_memory_write_enable
);
   typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;
   state_t      state_q, state_d;
   logic [15:0] ptr_q, ptr_d;
   logic [7:0]  inc_q, inc_d, fill_val_q, fill_val_d, count_q, count_d, data_rb_q, data_rb_d;
   logic        strobe_q, strobe_d;
   logic [10:0] tile_addr_q, tile_addr_d;
   logic [7:0]  tile_data_q, tile_data_d;
   logic        tile_en_q, tile_en_d;
   logic [11:0] attr_addr_q, attr_addr_d;
   logic [7:0]  attr_data_q, attr_data_d;
   logic        attr_en_q, attr_en_d;
   logic [3:0]  color_addr_q, color_addr_d;
   logic [7:0]  color_data_q, color_data_d;
   logic        color_en_q, color_en_d;
   logic        reg_wr, wr_go, tile_hit, attr_hit, color_hit;
   logic [7:0]  wr_data;

   // Register writes (only when idle, on a strobe rising edge), write sequencing and pointer advance
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      inc_d      = inc_q;
      fill_val_d = fill_val_q;
      count_d    = count_q;
      data_rb_d  = data_rb_q;
      strobe_d   = cpu_write_strobe;
      wr_go      = 1'b0;
      wr_data    = fill_val_q;
      reg_wr     = cpu_write_strobe && !strobe_q && state_q == IDLE;
      if (reg_wr) begin
         case (cpu_reg_sel)
            3'd0: ptr_d[7:0] = cpu_data_in;
            3'd1: ptr_d[15:8] = cpu_data_in;
            3'd2: begin
               wr_go     = 1'b1;
               wr_data   = cpu_data_in;
               data_rb_d = cpu_data_in;
               state_d   = WRITE;
            end
            3'd3: inc_d = cpu_data_in;
            3'd4: fill_val_d = cpu_data_in;
            3'd5: if (cpu_data_in != 8'd0) begin
               wr_go   = 1'b1;
               count_d = cpu_data_in - 8'd1;
               state_d = FILL;
            end
            default: ;
         endcase
      end else if (state_q == WRITE) begin
         state_d = IDLE;
      end else if (state_q == FILL) begin
         if (count_q != 8'd0) begin
            wr_go   = 1'b1;
            count_d = count_q - 8'd1;
         end else begin
            state_d = IDLE;
         end
      end
      if (wr_go) ptr_d = ptr_q + {8'h00, inc_q};
   end

   // Route a write to at most one memory; address/data hold while that memory is not written
   always_comb begin
      tile_hit     = wr_go && ptr_q[15:11] == 5'd0;
      attr_hit     = wr_go && ptr_q[15:12] == 4'h1;
      color_hit    = wr_go && ptr_q[15:4] == 12'h200;
      tile_en_d    = tile_hit;
      tile_addr_d  = tile_hit ? ptr_q[10:0] : tile_addr_q;
      tile_data_d  = tile_hit ? wr_data : tile_data_q;
      attr_en_d    = attr_hit;
      attr_addr_d  = attr_hit ? ptr_q[11:0] : attr_addr_q;
      attr_data_d  = attr_hit ? wr_data : attr_data_q;
      color_en_d   = color_hit;
      color_addr_d = color_hit ? ptr_q[3:0] : color_addr_q;
      color_data_d = color_hit ? wr_data : color_data_q;
   end

   // Combinational readback of the selected register
   always_comb begin
      cpu_data_out = 8'h00;
      case (cpu_reg_sel)
         3'd0: cpu_data_out = ptr_q[7:0];
         3'd1: cpu_data_out = ptr_q[15:8];
         3'd2: cpu_data_out = data_rb_q;
         3'd3: cpu_data_out = inc_q;
         3'd4: cpu_data_out = fill_val_q;
         3'd5: cpu_data_out = count_q;
         3'd6: cpu_data_out = {7'd0, state_q != IDLE};
         default: ;
      endcase
   end

   // State registers; reset aborts any fill and drops enables immediately
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         ptr_q        <= 16'h0000;
         inc_q        <= 8'd1;
         fill_val_q   <= 8'h00;
         count_q      <= 8'h00;
         data_rb_q    <= 8'h00;
         strobe_q     <= 1'b0;
         tile_addr_q  <= '0;
         tile_data_q  <= '0;
         tile_en_q    <= 1'b0;
         attr_addr_q  <= '0;
         attr_data_q  <= '0;
         attr_en_q    <= 1'b0;
         color_addr_q <= '0;
         color_data_q <= '0;
         color_en_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         inc_q        <= inc_d;
         fill_val_q   <= fill_val_d;
         count_q      <= count_d;
         data_rb_q    <= data_rb_d;
         strobe_q     <= strobe_d;
         tile_addr_q  <= tile_addr_d;
         tile_data_q  <= tile_data_d;
         tile_en_q    <= tile_en_d;
         attr_addr_q  <= attr_addr_d;
         attr_data_q  <= attr_data_d;
         attr_en_q    <= attr_en_d;
         color_addr_q <= color_addr_d;
         color_data_q <= color_data_d;
         color_en_q   <= color_en_d;
      end
   end

   assign tile_memory_write_addr        = tile_addr_q;
   assign tile_memory_write_data        = tile_data_q;
   assign tile_memory_write_enable      = tile_en_q;
   assign attribute_memory_write_addr   = attr_addr_q;
   assign attribute_memory_write_data   = attr_data_q;
   assign attribute_memory_write_enable = attr_en_q;
   assign color_memory_write_addr       = color_addr_q;
   assign color_memory_write_data       = color_data_q;
   assign color_memory_write_enable     = color_en_q;
endmodule

// File: tb/tb_vram_write_port.sv
// tb_vram_write_port: randomized scoreboard bench for vram_write_port against a register-level reference model
module tb_vram_write_port;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  sel = 3'd0;
   logic [7:0]  din = 8'h00;
   logic        stb = 1'b0;
   logic [7:0]  dout;
   logic [10:0] t_addr;
   logic [7:0]  t_data;
   logic        t_en;
   logic [11:0] a_addr;
   logic [7:0]  a_data;
   logic        a_en;
   logic [3:0]  c_addr;
   logic [7:0]  c_data;
   logic        c_en;

   vram_write_port dut (
      .clk(clk), .rst(rst), .cpu_reg_sel(sel), .cpu_data_in(din), .cpu_write_strobe(stb),
      .cpu_data_out(dout),
      .tile_memory_write_addr(t_addr), .tile_memory_write_data(t_data), .tile_memory_write_enable(t_en),
      .attribute_memory_write_addr(a_addr), .attribute_memory_write_data(a_data), .attribute_memory_write_enable(a_en),
      .color_memory_write_addr(c_addr), .color_memory_write_data(c_data), .color_memory_write_enable(c_en)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int mem; int addr; int data; int cyc;} exp_t;
   exp_t q[$];
   int tests = 0, fails = 0;
   int m_ptr, m_inc, m_fv, m_rb, busy_end;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      m_ptr = 0; m_inc = 1; m_fv = 0; m_rb = 0; busy_end = -10;
      q.delete();
   endfunction

   function automatic void push_write(input int p, input int d, input int c);
      exp_t e;
      if (p <= 'h07FF) begin e.mem = 0; e.addr = p; end
      else if (p >= 'h1000 && p <= 'h1FFF) begin e.mem = 1; e.addr = p - 'h1000; end
      else if (p >= 'h2000 && p <= 'h200F) begin e.mem = 2; e.addr = p - 'h2000; end
      else return;
      e.data = d; e.cyc = c;
      q.push_back(e);
   endfunction

   // s = cycle index at which the DUT shows the response to a strobe sampled on the preceding edge
   function automatic void model_write(input int s, input int r, input int d);
      if (s - 1 <= busy_end) return;
      case (r)
         0: m_ptr = (m_ptr & 'hFF00) | d;
         1: m_ptr = (m_ptr & 'h00FF) | (d << 8);
         2: begin
            push_write(m_ptr, d, s);
            m_rb = d; m_ptr = (m_ptr + m_inc) % 65536; busy_end = s;
         end
         3: m_inc = d;
         4: m_fv = d;
         5: if (d > 0) begin
            for (int i = 0; i < d; i++) begin
               push_write(m_ptr, m_fv, s + i);
               m_ptr = (m_ptr + m_inc) % 65536;
            end
            busy_end = s + d - 1;
         end
         default: ;
      endcase
   endfunction

   task automatic wr(input int r, input int d);
      @(negedge clk);
      sel = 3'(r); din = 8'(d); stb = 1'b1;
      model_write(cyc + 1, r, d);
      @(negedge clk);
      stb = 1'b0;
   endtask

   task automatic rd(input int r);
      int c, e;
      @(negedge clk);
      sel = 3'(r); stb = 1'b0;
      #1;
      c = cyc;
      if (r == 6) chk("status", int'(dout), (c <= busy_end) ? 1 : 0);
      else if (r == 5) chk("fill_count", int'(dout), (c <= busy_end) ? busy_end - c : 0);
      else if (r >= 2 || c > busy_end) begin
         e = (r == 0) ? (m_ptr & 'hFF) : (r == 1) ? (m_ptr >> 8) : (r == 2) ? m_rb :
             (r == 3) ? m_inc : (r == 4) ? m_fv : 0;
         chk($sformatf("readback_sel%0d", r), int'(dout), e);
      end
   endtask

   // Monitor: every asserted enable is matched in order against the scoreboard
   always @(negedge clk) begin : mon
      int n, m, a, d;
      exp_t e;
      if (rst) begin
         n = int'(t_en) + int'(a_en) + int'(c_en);
         if (q.size() > 0 && q[0].cyc < cyc) begin
            chk("missed_write_cycle", cyc, q[0].cyc);
            void'(q.pop_front());
         end
         if (n > 1) chk("one_hot_enable", n, 1);
         else if (n == 1) begin
            if (q.size() == 0) chk("unexpected_write", n, 0);
            else begin
               e = q.pop_front();
               m = t_en ? 0 : a_en ? 1 : 2;
               a = t_en ? int'(t_addr) : a_en ? int'(a_addr) : int'(c_addr);
               d = t_en ? int'(t_data) : a_en ? int'(a_data) : int'(c_data);
               chk("write_cycle", cyc, e.cyc);
               chk("write_mem", m, e.mem);
               chk("write_addr", a, e.addr);
               chk("write_data", d, e.data);
            end
         end
      end
   end

   initial begin
      int r, ws, wd;
      int hi_tab[8] = '{'h00, 'h03, 'h07, 'h10, 'h15, 'h1F, 'h20, 'hFF};
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset_enables", int'(t_en) + int'(a_en) + int'(c_en), 0);
      chk("reset_tile_addr", int'(t_addr), 0);
      chk("reset_attr_data", int'(a_data), 0);
      rst = 1'b1;
      rd(6); rd(3); rd(0); rd(1);
      // directed: tile, attribute, color, unmapped
      wr(1, 'h00); wr(0, 'h05); wr(2, 'hA7); rd(0); rd(1); rd(2);
      wr(1, 'h1A); wr(0, 'hBC); wr(2, 'h3C);
      wr(1, 'h20); wr(0, 'h03); wr(2, 'h1F);
      wr(0, 'h10); wr(2, 'h55); rd(0); rd(1);
      // fill with INC=2, DATA mid-fill must be dropped
      wr(3, 2); wr(1, 'h10); wr(0, 'h00); wr(4, 'hFF); wr(5, 4);
      rd(6); rd(5);
      wr(2, 'h99);
      repeat (5) @(negedge clk);
      rd(0); rd(1); rd(5); rd(6);
      // strobe held 5 cycles gives one write
      wr(3, 1); wr(1, 'h00); wr(0, 'h40);
      @(negedge clk);
      sel = 3'd2; din = 8'h66; stb = 1'b1;
      model_write(cyc + 1, 2, 'h66);
      repeat (4) @(negedge clk);
      stb = 1'b0;
      rd(0); rd(2);
      // pointer wrap
      wr(1, 'hFF); wr(0, 'hFF); wr(2, 'h12); rd(0); rd(1);
      wr(5, 0); rd(6); rd(7);
      // randomized traffic
      for (int i = 0; i < 250; i++) begin
         r = $urandom_range(0, 9);
         if (r < 6) begin
            ws = $urandom_range(0, 7);
            wd = (ws == 1) ? hi_tab[$urandom_range(0, 7)] :
                 (ws == 3) ? (($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 3)) :
                 (ws == 5) ? $urandom_range(0, 5) : $urandom_range(0, 255);
            wr(ws, wd);
         end else rd($urandom_range(0, 7));
      end
      repeat (10) @(negedge clk);
      // reset during a long fill
      wr(3, 1); wr(1, 'h00); wr(0, 'h00); wr(5, 200);
      repeat (10) @(negedge clk);
      chk("fill_active_before_reset", int'(t_en), 1);
      #2 rst = 1'b0;
      #1 chk("async_reset_enables", int'(t_en) + int'(a_en) + int'(c_en), 0);
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      rd(6); rd(0); rd(1); rd(3); rd(5);
      repeat (10) @(negedge clk);
      chk("queue_drain", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
